// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter: FSM states,
// requester IDs and byte-enable encodings.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } arbState_e;

    typedef enum logic [1:0] {
        REQ_ROM = 2'd0,
        REQ_A   = 2'd1,
        REQ_B   = 2'd2
    } reqId_e;

    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    // A byte write lands in the high lane for odd addresses, low lane otherwise.
    function automatic logic [1:0] romByteEnable(input logic addrLsb);
        return addrLsb ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter.sv
// Three-requester SDRAM arbiter (ROM loader writes, ports A/B reads), priority ROM > B > A.
// Define SDRAM_ARB_STARVE_GUARD_EN to let a starved port A jump ahead of port B.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              rom_wr,
    output logic              rom_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_rd,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_rd,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_be,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              ovf
);

    localparam int REP = DATA_W / 8;

    arbState_e         state_q, state_d;
    reqId_e            gnt_q, gnt_d;
    logic              romPend_q, romPend_d;
    logic [ADDR_W-1:0] romAddr_q, romAddr_d;
    logic [7:0]        romData_q, romData_d;
    logic              aPend_q, aPend_d;
    logic [ADDR_W-1:0] aAddr_q, aAddr_d;
    logic              bPend_q, bPend_d;
    logic [ADDR_W-1:0] bAddr_q, bAddr_d;
    logic              memReq_q, memReq_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [1:0]        memBe_q, memBe_d;
    logic [DATA_W-1:0] aDout_q, aDout_d;
    logic [DATA_W-1:0] bDout_q, bDout_d;
    logic              aReady_q, aReady_d;
    logic              bReady_q, bReady_d;
    logic              ovf_q, ovf_d;
    logic              grantValid;
    reqId_e            grantId;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= REQ_ROM;
            romPend_q  <= 1'b0;
            romAddr_q  <= '0;
            romData_q  <= '0;
            aPend_q    <= 1'b0;
            aAddr_q    <= '0;
            bPend_q    <= 1'b0;
            bAddr_q    <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memBe_q    <= '0;
            aDout_q    <= '0;
            bDout_q    <= '0;
            aReady_q   <= 1'b0;
            bReady_q   <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
            starveCnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            romPend_q  <= romPend_d;
            romAddr_q  <= romAddr_d;
            romData_q  <= romData_d;
            aPend_q    <= aPend_d;
            aAddr_q    <= aAddr_d;
            bPend_q    <= bPend_d;
            bAddr_q    <= bAddr_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            memBe_q    <= memBe_d;
            aDout_q    <= aDout_d;
            bDout_q    <= bDout_d;
            aReady_q   <= aReady_d;
            bReady_q   <= bReady_d;
            ovf_q      <= ovf_d;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
            starveCnt_q <= starveCnt_d;
`endif
        end
    end

    // Arbitration looks only at registered pending bits, so a pulse waits one cycle.
    always_comb begin
        grantValid = 1'b1;
        grantId    = REQ_ROM;
        if (romPend_q) begin
            grantId = REQ_ROM;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
        end else if (aPend_q && (starveCnt_q == STARVE_LIM)) begin
            grantId = REQ_A;
`endif
        end else if (bPend_q) begin
            grantId = REQ_B;
        end else if (aPend_q) begin
            grantId = REQ_A;
        end else begin
            grantValid = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        romPend_d  = romPend_q;
        romAddr_d  = romAddr_q;
        romData_d  = romData_q;
        aPend_d    = aPend_q;
        aAddr_d    = aAddr_q;
        bPend_d    = bPend_q;
        bAddr_d    = bAddr_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        memBe_d    = memBe_q;
        aDout_d    = aDout_q;
        bDout_d    = bDout_q;
        aReady_d   = 1'b0;
        bReady_d   = 1'b0;
        ovf_d      = ovf_q;

        // Clearing on ack before latching lets a same-cycle pulse start a fresh request.
        if (state_q == ST_ISSUE && mem_ack) begin
            case (gnt_q)
                REQ_ROM: romPend_d = 1'b0;
                REQ_A:   aPend_d   = 1'b0;
                REQ_B:   bPend_d   = 1'b0;
                default: ;
            endcase
        end

        if (rom_wr) begin
            if (romPend_d) begin
                ovf_d = 1'b1;
            end else begin
                romPend_d = 1'b1;
                romAddr_d = rom_addr;
                romData_d = rom_data;
            end
        end
        if (a_rd) begin
            if (aPend_d) begin
                ovf_d = 1'b1;
            end else begin
                aPend_d = 1'b1;
                aAddr_d = a_addr;
            end
        end
        if (b_rd) begin
            if (bPend_d) begin
                ovf_d = 1'b1;
            end else begin
                bPend_d = 1'b1;
                bAddr_d = b_addr;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (grantValid) begin
                    gnt_d    = grantId;
                    memReq_d = 1'b1;
                    state_d  = ST_ISSUE;
                    case (grantId)
                        REQ_ROM: begin
                            memWe_d    = 1'b1;
                            memAddr_d  = romAddr_q;
                            memWdata_d = {REP{romData_q}};
                            memBe_d    = romByteEnable(romAddr_q[0]);
                        end
                        REQ_A: begin
                            memWe_d   = 1'b0;
                            memAddr_d = aAddr_q;
                            memBe_d   = BE_WORD;
                        end
                        default: begin
                            memWe_d   = 1'b0;
                            memAddr_d = bAddr_q;
                            memBe_d   = BE_WORD;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    memReq_d = 1'b0;
                    state_d  = (gnt_q == REQ_ROM) ? ST_IDLE : ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                    if (gnt_q == REQ_A) begin
                        aDout_d  = mem_rdata;
                        aReady_d = 1'b1;
                    end else begin
                        bDout_d  = mem_rdata;
                        bReady_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    // A counts as waiting only while pending and not already the transaction in flight.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (state_q == ST_IDLE && grantValid && grantId == REQ_A) begin
            starveCnt_d = '0;
        end else if (aPend_q && !(state_q != ST_IDLE && gnt_q == REQ_A)
                     && starveCnt_q != STARVE_LIM) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
    end
`endif

    assign rom_ready = ~romPend_q;
    assign busy      = (state_q != ST_IDLE) | romPend_q | aPend_q | bPend_q;
    assign ovf       = ovf_q;
    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign mem_be    = memBe_q;
    assign a_dout    = aDout_q;
    assign a_ready   = aReady_q;
    assign b_dout    = bDout_q;
    assign b_ready   = bReady_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter; the memory side is driven by hand.
// Expected grant order for the starvation scenario follows SDRAM_ARB_STARVE_GUARD_EN.
module tb_sdram_port_arbiter;

    localparam int ADDR_W     = 25;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              rom_wr;
    logic              rom_ready;
    logic [ADDR_W-1:0] a_addr;
    logic              a_rd;
    logic [DATA_W-1:0] a_dout;
    logic              a_ready;
    logic [ADDR_W-1:0] b_addr;
    logic              b_rd;
    logic [DATA_W-1:0] b_dout;
    logic              b_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_be;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    sdram_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_wr    (rom_wr),
        .rom_ready (rom_ready),
        .a_addr    (a_addr),
        .a_rd      (a_rd),
        .a_dout    (a_dout),
        .a_ready   (a_ready),
        .b_addr    (b_addr),
        .b_rd      (b_rd),
        .b_dout    (b_dout),
        .b_ready   (b_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic stepClock(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_memReq"},   32'(mem_req),   32'h0);
        checkOutput({pfx, "_memWe"},    32'(mem_we),    32'h0);
        checkOutput({pfx, "_memAddr"},  32'(mem_addr),  32'h0);
        checkOutput({pfx, "_memWdata"}, 32'(mem_wdata), 32'h0);
        checkOutput({pfx, "_memBe"},    32'(mem_be),    32'h0);
        checkOutput({pfx, "_aDout"},    32'(a_dout),    32'h0);
        checkOutput({pfx, "_bDout"},    32'(b_dout),    32'h0);
        checkOutput({pfx, "_aReady"},   32'(a_ready),   32'h0);
        checkOutput({pfx, "_bReady"},   32'(b_ready),   32'h0);
        checkOutput({pfx, "_ovf"},      32'(ovf),       32'h0);
        checkOutput({pfx, "_busy"},     32'(busy),      32'h0);
        checkOutput({pfx, "_romReady"}, 32'(rom_ready), 32'h1);
    endtask

    // Waits (bounded) for mem_req, acks it, and returns read data one cycle later.
    task automatic serveMem(input logic [DATA_W-1:0] rdata, input bit repulseB,
                            output logic [ADDR_W-1:0] addr, output logic we,
                            output logic [1:0] be, output bit ok, output bit pulsedB);
        ok      = 1'b0;
        pulsedB = 1'b0;
        addr    = '0;
        we      = 1'b0;
        be      = '0;
        for (int i = 0; i < 40; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            stepClock(1);
        end
        if (ok) begin
            addr    = mem_addr;
            we      = mem_we;
            be      = mem_be;
            mem_ack = 1'b1;
            if (repulseB && mem_addr == b_addr) begin
                b_rd    = 1'b1;
                pulsedB = 1'b1;
            end
            stepClock(1);
            mem_ack = 1'b0;
            b_rd    = 1'b0;
            if (!we) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata;
                stepClock(1);
                mem_rvalid = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] gAddr;
        logic              gWe;
        logic [1:0]        gBe;
        bit                ok;
        bit                pulsed;
        int                extra;
        int                bLeft;
        logic [ADDR_W-1:0] expOrder [6];

        reset      = 1'b1;
        rom_addr   = '0;
        rom_data   = '0;
        rom_wr     = 1'b0;
        a_addr     = '0;
        a_rd       = 1'b0;
        b_addr     = '0;
        b_rd       = 1'b0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        stepClock(2);
        checkResetValues("rst0");
        reset = 1'b0;
        stepClock(1);

        $display("[TB] single A read, plus a re-request in the ack cycle");
        a_addr = 25'h000100;
        a_rd   = 1'b1;
        stepClock(1);
        a_rd = 1'b0;
        checkOutput("t1_reqNotYet", 32'(mem_req), 32'h0);
        checkOutput("t1_busyPend",  32'(busy),    32'h1);
        stepClock(1);
        checkOutput("t1_reqHigh1", 32'(mem_req),  32'h1);
        checkOutput("t1_addr",     32'(mem_addr), 32'h100);
        checkOutput("t1_we",       32'(mem_we),   32'h0);
        checkOutput("t1_be",       32'(mem_be),   32'h3);
        stepClock(1);
        checkOutput("t1_reqHigh2", 32'(mem_req),  32'h1);
        checkOutput("t1_addrHeld", 32'(mem_addr), 32'h100);
        mem_ack = 1'b1;
        a_rd    = 1'b1;
        a_addr  = 25'h000044;
        stepClock(1);
        mem_ack = 1'b0;
        a_rd    = 1'b0;
        checkOutput("t1_reqDrop",    32'(mem_req), 32'h0);
        checkOutput("t1_ovfAckPuls", 32'(ovf),     32'h0);
        stepClock(2);
        checkOutput("t1_noEarlyRdy", 32'(a_ready), 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
        stepClock(1);
        mem_rvalid = 1'b0;
        checkOutput("t1_aDout",  32'(a_dout),  32'hBEEF);
        checkOutput("t1_aReady", 32'(a_ready), 32'h1);
        checkOutput("t1_bReady", 32'(b_ready), 32'h0);
        stepClock(1);
        checkOutput("t1_aReadyPulse", 32'(a_ready),  32'h0);
        checkOutput("t1_aDoutHeld",   32'(a_dout),   32'hBEEF);
        checkOutput("t1_secondReq",   32'(mem_req),  32'h1);
        checkOutput("t1_secondAddr",  32'(mem_addr), 32'h44);
        serveMem(16'h1111, 1'b0, gAddr, gWe, gBe, ok, pulsed);
        checkOutput("t1_serveOk",  32'(ok),     32'h1);
        checkOutput("t1_aDout2",   32'(a_dout), 32'h1111);
        stepClock(1);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        stepClock(1);
        mem_rvalid = 1'b0;
        checkOutput("t1_idleRvA",   32'(a_ready), 32'h0);
        checkOutput("t1_idleRvB",   32'(b_ready), 32'h0);
        checkOutput("t1_idleRvDat", 32'(a_dout),  32'h1111);

        $display("[TB] ROM byte write to odd address");
        rom_addr = 25'h000003;
        rom_data = 8'h5A;
        rom_wr   = 1'b1;
        stepClock(1);
        rom_wr = 1'b0;
        checkOutput("t2_romReadyLow", 32'(rom_ready), 32'h0);
        stepClock(1);
        checkOutput("t2_req",      32'(mem_req),   32'h1);
        checkOutput("t2_we",       32'(mem_we),    32'h1);
        checkOutput("t2_wdata",    32'(mem_wdata), 32'h5A5A);
        checkOutput("t2_be",       32'(mem_be),    32'h2);
        checkOutput("t2_addr",     32'(mem_addr),  32'h3);
        checkOutput("t2_romReady", 32'(rom_ready), 32'h0);
        mem_ack = 1'b1;
        stepClock(1);
        mem_ack = 1'b0;
        checkOutput("t2_reqDrop",    32'(mem_req),   32'h0);
        checkOutput("t2_romReadyHi", 32'(rom_ready), 32'h1);
        checkOutput("t2_idle",       32'(busy),      32'h0);

        $display("[TB] simultaneous ROM, A, B requests");
        rom_addr = 25'h000010;
        rom_data = 8'hC3;
        a_addr   = 25'h000030;
        b_addr   = 25'h000020;
        rom_wr   = 1'b1;
        a_rd     = 1'b1;
        b_rd     = 1'b1;
        stepClock(1);
        rom_wr = 1'b0;
        a_rd   = 1'b0;
        b_rd   = 1'b0;
        serveMem(16'h0000, 1'b0, gAddr, gWe, gBe, ok, pulsed);
        checkOutput("t3_firstAddr", 32'(gAddr), 32'h10);
        checkOutput("t3_firstWe",   32'(gWe),   32'h1);
        checkOutput("t3_firstBe",   32'(gBe),   32'h1);
        serveMem(16'h2222, 1'b0, gAddr, gWe, gBe, ok, pulsed);
        checkOutput("t3_secondAddr", 32'(gAddr),  32'h20);
        checkOutput("t3_bDout",      32'(b_dout), 32'h2222);
        serveMem(16'h3333, 1'b0, gAddr, gWe, gBe, ok, pulsed);
        checkOutput("t3_thirdAddr", 32'(gAddr),  32'h30);
        checkOutput("t3_aDout",     32'(a_dout), 32'h3333);
        extra = 0;
        repeat (6) begin
            stepClock(1);
            if (mem_req) extra++;
        end
        checkOutput("t3_noFourth", 32'(extra), 32'h0);

        $display("[TB] A pending while B keeps re-requesting");
`ifdef SDRAM_ARB_STARVE_GUARD_EN
        expOrder = '{25'h400, 25'h400, 25'h400, 25'h300, 25'h400, 25'h400};
`else
        expOrder = '{25'h400, 25'h400, 25'h400, 25'h400, 25'h400, 25'h300};
`endif
        a_addr = 25'h000300;
        b_addr = 25'h000400;
        a_rd   = 1'b1;
        b_rd   = 1'b1;
        stepClock(1);
        a_rd  = 1'b0;
        b_rd  = 1'b0;
        bLeft = 4;
        for (int k = 0; k < 6; k++) begin
            serveMem(16'(k), bLeft > 0, gAddr, gWe, gBe, ok, pulsed);
            if (pulsed) bLeft--;
            checkOutput($sformatf("t4_grant%0d", k), 32'(gAddr), 32'(expOrder[k]));
        end
        stepClock(3);
        checkOutput("t4_drained", 32'(busy), 32'h0);

        $display("[TB] overrun on port A");
        a_addr = 25'h000050;
        a_rd   = 1'b1;
        stepClock(1);
        a_addr = 25'h000060;
        stepClock(1);
        a_rd = 1'b0;
        checkOutput("t5_ovf", 32'(ovf), 32'h1);
        serveMem(16'h5555, 1'b0, gAddr, gWe, gBe, ok, pulsed);
        checkOutput("t5_addr", 32'(gAddr), 32'h50);
        extra = 0;
        repeat (6) begin
            stepClock(1);
            if (mem_req) extra++;
        end
        checkOutput("t5_oneRead",   32'(extra), 32'h0);
        checkOutput("t5_ovfSticky", 32'(ovf),   32'h1);

        $display("[TB] reset during WAIT_RD");
        b_addr = 25'h000070;
        b_rd   = 1'b1;
        stepClock(1);
        b_rd = 1'b0;
        stepClock(1);
        checkOutput("t6_req", 32'(mem_req), 32'h1);
        mem_ack = 1'b1;
        stepClock(1);
        mem_ack = 1'b0;
        reset   = 1'b1;
        stepClock(1);
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h9999;
        stepClock(1);
        mem_rvalid = 1'b0;
        checkResetValues("t6");
        stepClock(1);
        checkOutput("t6_noLateReady", 32'(b_ready), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, meaning SDRAM byte address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning SDRAM word width.
REQ-003 SHALL have parameter STARVE_MAX, default 8, meaning cycles port A may wait before forced grant.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have the ROM-loader ports: rom_addr input ADDR_W, rom_data input 8, rom_wr input 1 (one-cycle pulse), and rom_ready output 1.
REQ-007 SHALL have port A ports: a_addr input ADDR_W, a_rd input 1 (pulse), a_dout output DATA_W, a_ready output 1 (pulse).
REQ-008 SHALL have port B ports: b_addr input ADDR_W, b_rd input 1 (pulse), b_dout output DATA_W, b_ready output 1 (pulse).
REQ-009 SHALL have the memory-side outputs mem_req 1, mem_we 1, mem_addr ADDR_W, mem_wdata DATA_W and mem_be 2.
REQ-010 SHALL have the memory-side inputs mem_ack 1 (command accepted), mem_rvalid 1 and mem_rdata DATA_W.
REQ-011 SHALL have the status outputs busy 1 (FSM not IDLE or any request pending) and ovf 1 (sticky overrun flag).

Function
REQ-012 SHALL latch each rom_wr, a_rd and b_rd pulse, with its address and data, into a one-deep pending register per requester.
REQ-013 SHALL ignore a request pulse that arrives while that requester is already pending, and SHALL set ovf in that case; ovf is cleared only by reset.
REQ-014 SHALL hold rom_ready low while the ROM request is pending, and high otherwise.
REQ-015 SHALL implement an FSM with states IDLE, ISSUE and WAIT_RD.
REQ-016 SHALL arbitrate in IDLE with the priority ROM > B > A; a request latched in cycle N is eligible for grant in cycle N+1.
REQ-017 SHALL, on grant, register mem_req=1 and the granted addr/we/wdata/be, then enter ISSUE.
REQ-018 SHALL hold mem_req and the command fields stable in ISSUE until mem_ack=1.
REQ-019 SHALL, on mem_ack, drop mem_req the next cycle and clear the granted pending bit; a write then returns to IDLE, a read moves to WAIT_RD.
REQ-020 SHALL, in WAIT_RD on mem_rvalid, register mem_rdata into a_dout or b_dout, pulse the matching a_ready or b_ready for exactly one cycle, and return to IDLE.
REQ-021 SHALL retain a_dout and b_dout between transfers.
REQ-022 SHALL ignore mem_rvalid when the FSM is in IDLE or ISSUE.
REQ-023 SHALL form ROM writes with mem_we=1, mem_wdata={rom_data,rom_data} and mem_be=2'b10 if rom_addr[0] else 2'b01.
REQ-024 SHALL issue reads with mem_we=0 and mem_be=2'b11.
REQ-025 SHALL accept a new pulse on a requester in the same cycle its previous request is acked; that pulse becomes a new pending request.
REQ-026 SHALL update the starvation counter as follows: it increments each cycle A is pending and not granted, saturates at STARVE_MAX and clears when A is granted.

Reset
REQ-027 SHALL, on reset, set: FSM=IDLE; all pending bits=0; starvation counter=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_be=0; a_dout=0; b_dout=0; a_ready=0; b_ready=0; ovf=0; busy=0; rom_ready=1.
REQ-028 SHALL abandon any in-flight transaction when reset is asserted mid-operation; a read response arriving after reset is discarded per REQ-022.

Configuration
REQ-029 SHALL, with macro SDRAM_ARB_STARVE_GUARD_EN defined, grant A ahead of B (never ahead of ROM) when the starvation counter equals STARVE_MAX.
REQ-030 SHALL, with SDRAM_ARB_STARVE_GUARD_EN undefined, omit the counter and use strict ROM > B > A priority.

Structure
REQ-031 SHALL take the FSM state enum, the requester-ID enum (REQ_ROM, REQ_A, REQ_B) and the BE constants from a shared package, sdram_arb_pkg.
REQ-032 SHALL be one module with no sub-modules; the per-requester pending register is small enough to inline.

Verification
REQ-033 SHALL cover: a_rd @0x000100, mem_ack after 2 cycles, mem_rvalid with 0xBEEF after 3 more -> mem_req high 2 cycles, a_dout=0xBEEF, a_ready pulses 1 cycle.
REQ-034 SHALL cover: a_rd, b_rd and rom_wr in the same cycle -> grant order ROM, B, A, with exactly three mem_req transactions.
REQ-035 SHALL cover: rom_wr addr=0x000003 data=0x5A -> mem_be=2'b10, mem_wdata=0x5A5A, mem_we=1, rom_ready low until ack.
REQ-036 SHALL cover, with the guard enabled: A pending while B is re-requested every transaction, STARVE_MAX=8 -> A granted once its counter reaches 8; with the guard disabled, A waits until B stops requesting.
REQ-037 SHALL cover: a second a_rd while A is pending -> ovf=1 and only one read issued.
REQ-038 SHALL cover: reset asserted during WAIT_RD, then mem_rvalid -> no a_ready or b_ready pulse, and all outputs at their reset values.
